baud_tick_gen_frac: RTL

//   Programmable fractional baud-rate generator for the UART TX/RX datapaths.
//   - Runtime divisor with integer and fractional parts.
//   - Oversample tick (os_tick), mid-bit sample tick (mid_tick) and bit tick (bit_tick).
//   - Divisor changes apply glitch-free at a tick boundary; sync restart aligns phase to a start bit.

---
 rtl/baud_tick_gen_frac_if.sv | 42 ++++
 rtl/baud_tick_gen_frac.sv | 130 +++++++++++++
 2 files changed

// File: rtl/baud_tick_gen_frac_if.sv
// ---------------------------------------------------------------------------
// baud_tick_gen_frac_if
//   Control / tick bundle of the fractional baud-rate generator.
//   master : the UART side that sets the divisor and consumes the ticks
//   slave  : the generator itself
//   Signals
//     en, restart           count enable and phase restart
//     div_int, div_frac     divisor to be loaded, sampled on div_load
//     div_load              1-cycle load strobe
//     div_pend, cfg_err     load status
//     os_tick, mid_tick,
//     bit_tick, os_idx      timing outputs
// ---------------------------------------------------------------------------
interface baud_tick_gen_frac_if #(
    parameter int CNT_W  = 16,
    parameter int FRAC_W = 4,
    parameter int OVS    = 16
);
    localparam int IDX_W = $clog2(OVS);

    logic              en;
    logic              restart;
    logic [CNT_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              div_pend;
    logic              cfg_err;
    logic              os_tick;
    logic              mid_tick;
    logic              bit_tick;
    logic [IDX_W-1:0]  os_idx;

    modport master (
        output en, restart, div_int, div_frac, div_load,
        input  div_pend, cfg_err, os_tick, mid_tick, bit_tick, os_idx
    );

    modport slave (
        input  en, restart, div_int, div_frac, div_load,
        output div_pend, cfg_err, os_tick, mid_tick, bit_tick, os_idx
    );
endinterface

// File: rtl/baud_tick_gen_frac.sv
// ---------------------------------------------------------------------------
// baud_tick_gen_frac
//   Fractional baud-rate generator. A period counter runs to act_int+ext,
//   where ext is the carry of a FRAC_W-bit accumulator stepped by act_frac
//   on every oversample tick, so the long-term period is
//   act_int + act_frac/2^FRAC_W clocks. Every OVS oversample ticks form one
//   bit; mid_tick and bit_tick mark the sample point and the bit end.
//   Ports
//     clk   system clock
//     rst   asynchronous reset, active low
//     bus   baud_tick_gen_frac_if.slave (controls, divisor load, ticks)
// ---------------------------------------------------------------------------
module baud_tick_gen_frac #(
    parameter int CNT_W    = 16,
    parameter int FRAC_W   = 4,
    parameter int OVS      = 16,
    parameter int DEF_INT  = 325,
    parameter int DEF_FRAC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    baud_tick_gen_frac_if.slave  bus
);
    localparam int IDX_W = $clog2(OVS);

    logic [CNT_W-1:0]  act_int_r;
    logic [FRAC_W-1:0] act_frac_r;
    logic [CNT_W-1:0]  shd_int_r;
    logic [FRAC_W-1:0] shd_frac_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [FRAC_W-1:0] frac_acc_r;
    logic              ext_r;
    logic [IDX_W-1:0]  os_idx_r;
    logic              div_pend_r;
    logic              cfg_err_r;

    logic [CNT_W:0]    len_m1_s;
    logic [FRAC_W:0]   sum_s;
    logic              os_tick_s;
    logic              apply_s;
    logic              load_ok_s;
    logic              load_bad_s;

    // Period decode, accumulator sum, divisor apply/load qualification.
    always_comb begin
        // One bit wider than the counter so act_int=max with ext=1 cannot wrap.
        len_m1_s   = {1'b0, act_int_r} + {{CNT_W{1'b0}}, ext_r} - {{CNT_W{1'b0}}, 1'b1};
        // Restart owns the cycle, so it suppresses a tick that would otherwise fire.
        os_tick_s  = bus.en & ~bus.restart & ({1'b0, cnt_r} == len_m1_s);
        sum_s      = {1'b0, frac_acc_r} + {1'b0, act_frac_r};
        // div_pend_r is a flop, so an apply can only happen strictly after the load cycle.
        apply_s    = div_pend_r & (os_tick_s | bus.restart | ~bus.en);
        load_ok_s  = bus.div_load & (bus.div_int >= CNT_W'(2));
        load_bad_s = bus.div_load & ~load_ok_s;
    end

    // Period counter, fractional accumulator and oversample index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r      <= {CNT_W{1'b0}};
            frac_acc_r <= {FRAC_W{1'b0}};
            ext_r      <= 1'b0;
            os_idx_r   <= {IDX_W{1'b0}};
        end else if (bus.restart) begin
            cnt_r      <= {CNT_W{1'b0}};
            frac_acc_r <= {FRAC_W{1'b0}};
            ext_r      <= 1'b0;
            os_idx_r   <= {IDX_W{1'b0}};
        end else if (os_tick_s) begin
            cnt_r      <= {CNT_W{1'b0}};
            frac_acc_r <= sum_s[FRAC_W-1:0];
            // The carry stretches the period that starts now, i.e. the one after the overflow.
            ext_r      <= sum_s[FRAC_W];
            os_idx_r   <= (os_idx_r == IDX_W'(OVS - 1)) ? {IDX_W{1'b0}} : os_idx_r + IDX_W'(1);
        end else if (bus.en) begin
            cnt_r      <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r      <= cnt_r;
            frac_acc_r <= frac_acc_r;
            ext_r      <= ext_r;
            os_idx_r   <= os_idx_r;
        end
    end

    // Active/shadow divisor registers and load status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_int_r  <= CNT_W'(DEF_INT);
            act_frac_r <= FRAC_W'(DEF_FRAC);
            shd_int_r  <= CNT_W'(DEF_INT);
            shd_frac_r <= FRAC_W'(DEF_FRAC);
            div_pend_r <= 1'b0;
            cfg_err_r  <= 1'b0;
        end else begin
            // Apply uses the shadow as it was before any load in this same cycle.
            if (apply_s) begin
                act_int_r  <= shd_int_r;
                act_frac_r <= shd_frac_r;
            end else begin
                act_int_r  <= act_int_r;
                act_frac_r <= act_frac_r;
            end
            if (load_ok_s) begin
                shd_int_r  <= bus.div_int;
                shd_frac_r <= bus.div_frac;
                div_pend_r <= 1'b1;
                cfg_err_r  <= 1'b0;
            end else if (load_bad_s) begin
                shd_int_r  <= shd_int_r;
                shd_frac_r <= shd_frac_r;
                div_pend_r <= div_pend_r & ~apply_s;
                cfg_err_r  <= 1'b1;
            end else begin
                shd_int_r  <= shd_int_r;
                shd_frac_r <= shd_frac_r;
                div_pend_r <= div_pend_r & ~apply_s;
                cfg_err_r  <= cfg_err_r;
            end
        end
    end

    // Ticks are decoded from state plus en so they coincide with the counter wrap.
    assign bus.os_tick  = os_tick_s;
    assign bus.mid_tick = os_tick_s & (os_idx_r == IDX_W'(OVS / 2 - 1));
    assign bus.bit_tick = os_tick_s & (os_idx_r == IDX_W'(OVS - 1));
    assign bus.os_idx   = os_idx_r;
    assign bus.div_pend = div_pend_r;
    assign bus.cfg_err  = cfg_err_r;

endmodule
